// File: rtl/spi_master.sv
// Byte-oriented full-duplex SPI master, mode 0 (sclk idles low, data sampled
// on sclk rising edges), MSB first in both directions. Each accepted start
// rising edge runs one 8-bit exchange and ends with a single-cycle done pulse.
module spi_master #(
    parameter int HALF_PERIOD = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       buzy,
    output logic       done,
    output logic [7:0] data_out,
    output logic       cs,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    // Half-period counter runs 0..HALF_PERIOD-1; sclk toggles on the last count.
    localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             start_d_q, start_d_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic             buzy_q, buzy_d;
    logic             done_q, done_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             start_rise;

    assign start_rise = start && !start_d_q;

    // Next-state logic: start edge detect, sclk generation and the shift datapath.
    always_comb begin
        state_d    = state_q;
        start_d_d  = start;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        buzy_d     = buzy_q;
        done_d     = 1'b0;
        data_out_d = data_out_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    tx_d    = data_in;
                    rx_d    = 8'h00;
                    cs_d    = 1'b0;
                    buzy_d  = 1'b1;
                    mosi_d  = data_in[7];
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    sclk_d  = 1'b0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    sclk_d = !sclk_q;
                    if (!sclk_q) begin
                        // Rising sclk: capture the miso value present before this edge.
                        rx_d = {rx_q[6:0], miso};
                    end else if (bit_q == 3'd7) begin
                        // Eighth falling sclk: publish the byte and release the slave.
                        bit_d      = 3'd0;
                        data_out_d = rx_q;
                        cs_d       = 1'b1;
                        buzy_d     = 1'b0;
                        done_d     = 1'b1;
                        mosi_d     = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        tx_d   = {tx_q[6:0], 1'b0};
                        mosi_d = tx_q[6];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset wins over any start edge sampled on the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            start_d_q  <= 1'b0;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            buzy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= 8'h00;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_d_q  <= start_d_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            buzy_q     <= buzy_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    assign buzy     = buzy_q;
    assign done     = done_q;
    assign data_out = data_out_q;
    assign cs       = cs_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed and randomized bench for spi_master: a mode-0 slave model or a
// loopback drives miso, and expected bytes/bit streams come from plain arithmetic.
module tb_spi_master;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic       buzy, done, cs, sclk, mosi, miso;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int sclk_rises = 0;
  logic mosi_seen[$];

  logic       loopback = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  logic [2:0] slave_idx = 3'd7;

  spi_master #(.HALF_PERIOD(H)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .buzy(buzy), .done(done), .data_out(data_out), .cs(cs),
    .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  // clock
  always #5 clk = ~clk;

  // slave model: presents MSB when selected, advances on each falling sclk
  assign miso = loopback ? mosi : slave_byte[slave_idx];
  always @(negedge cs) slave_idx = 3'd7;
  always @(negedge sclk) slave_idx = slave_idx - 3'd1;

  // monitors
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  always @(posedge sclk) begin
    sclk_rises++;
    mosi_seen.push_back(mosi);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive a start edge, check the acceptance edge; optionally leave start high
  task automatic launch(input logic [7:0] d, input bit hold);
    @(negedge clk);
    data_in = d;
    start = 1'b1;
    mosi_seen.delete();
    @(posedge clk);
    #1;
    check("accept_cs", 32'(cs), 32'd0);
    check("accept_buzy", 32'(buzy), 32'd1);
    check("accept_mosi", 32'(mosi), 32'(d[7]));
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // wait for done (bounded) and compare against the reference expectations
  task automatic complete(input logic [7:0] tx, input logic [7:0] exp_rx, input int inject_at);
    int cyc;
    int cs_low;
    int d0;
    bit seen;
    d0 = done_cnt;
    cs_low = 1;
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == inject_at) begin
        data_in = 8'hFF;
        start = 1'b1;
      end else if (cyc == inject_at + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) seen = 1;
      else if (cs === 1'b0) cs_low++;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'(16 * H));
    check("buzy_at_done", 32'(buzy), 32'd0);
    check("cs_at_done", 32'(cs), 32'd1);
    check("sclk_at_done", 32'(sclk), 32'd0);
    check("mosi_at_done", 32'(mosi), 32'd0);
    check("data_out", 32'(data_out), 32'(exp_rx));
    check("cs_low_cycles", 32'(cs_low), 32'(16 * H));
    check("mosi_bit_count", 32'(mosi_seen.size()), 32'd8);
    for (int i = 0; i < 8 && i < mosi_seen.size(); i++)
      check("mosi_bit", 32'(mosi_seen[i]), (32'(tx) >> (7 - i)) & 32'd1);
    @(posedge clk);
    #1;
    check("done_clears", 32'(done), 32'd0);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("data_out_hold", 32'(data_out), 32'(exp_rx));
  endtask

  initial begin
    int d0;
    int r0;
    logic [7:0] d, sb;
    bit lb;

    // reset held for 5 cycles
    reset = 1'b0;
    start = 1'b0;
    data_in = 8'h00;
    r0 = sclk_rises;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("rst_cs", 32'(cs), 32'd1);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_buzy", 32'(buzy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
    end
    check("rst_no_sclk", 32'(sclk_rises - r0), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // loopback A5
    loopback = 1'b1;
    launch(8'hA5, 0);
    complete(8'hA5, 8'hA5, -1);

    // slave returns 8E while master sends 00
    loopback = 1'b0;
    slave_byte = 8'h8E;
    launch(8'h00, 0);
    complete(8'h00, 8'h8E, -1);

    // start held high for 100 cycles
    loopback = 1'b1;
    d0 = done_cnt;
    launch(8'h3C, 1);
    complete(8'h3C, 8'h3C, -1);
    repeat (100 - 16 * H - 3) @(posedge clk);
    #1;
    check("held_one_done", 32'(done_cnt - d0), 32'd1);
    check("held_idle", 32'(buzy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    launch(8'hC3, 0);
    complete(8'hC3, 8'hC3, -1);

    // second start mid-transfer with data_in=FF is ignored
    d0 = done_cnt;
    launch(8'h4D, 0);
    complete(8'h4D, 8'h4D, 10);
    repeat (40) @(posedge clk);
    #1;
    check("ignored_start_dones", 32'(done_cnt - d0), 32'd1);

    // transfer leaving data_out=00, then reset mid-transfer
    loopback = 1'b0;
    slave_byte = 8'h00;
    launch(8'h96, 0);
    complete(8'h96, 8'h00, -1);
    d0 = done_cnt;
    launch(8'h6B, 0);
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_cs", 32'(cs), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_buzy", 32'(buzy), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd0);
    check("abort_data_out", 32'(data_out), 32'd0);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle_cs", 32'(cs), 32'd1);
    loopback = 1'b1;
    launch(8'h11, 0);
    complete(8'h11, 8'h11, -1);

    // randomized transfers
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom_range(0, 255));
      sb = 8'($urandom_range(0, 255));
      lb = 1'($urandom_range(0, 1));
      loopback = lb;
      slave_byte = sb;
      launch(d, 0);
      complete(d, lb ? d : sb, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
